// File: rtl/chol_pkg.sv
// Shared types and widths for the Cholesky accumulation datapath.
// CHOL_MAC_LATENCY must track the pipeline depth of the generated MAC core.
package chol_pkg;

    localparam int CHOL_OP_W        = 32;
    localparam int CHOL_ACC_W       = 64;
    localparam int CHOL_MAC_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } chol_state_e;

endpackage

// File: rtl/chol_acc_ctrl_if.sv
// Bundle of control, operand, MAC and result signals for chol_acc_ctrl.
// Optional op_add exists only when CHOL_ACC_ADD_EN is defined.
interface chol_acc_ctrl_if
    import chol_pkg::*;
#(
    parameter int CNT_W = 6
);
`ifdef CHOL_ACC_ADD_EN
    logic                  op_add;
`endif
    logic                  start;
    logic [CHOL_ACC_W-1:0] init_c;
    logic [CNT_W-1:0]      n_terms;
    logic                  busy;
    logic                  term_valid;
    logic                  term_ready;
    logic [CHOL_OP_W-1:0]  term_a;
    logic [CHOL_OP_W-1:0]  term_b;
    logic [CHOL_OP_W-1:0]  mac_a;
    logic [CHOL_OP_W-1:0]  mac_b;
    logic [CHOL_ACC_W-1:0] mac_c;
    logic                  mac_sub;
    logic                  mac_clken;
    logic [CHOL_ACC_W-1:0] mac_out;
    logic                  res_valid;
    logic                  res_ready;
    logic [CHOL_ACC_W-1:0] res_data;

    // Upstream/parent view: drives requests, operands, MAC result and res_ready.
    modport master (
`ifdef CHOL_ACC_ADD_EN
        output op_add,
`endif
        output start, init_c, n_terms, term_valid, term_a, term_b, mac_out, res_ready,
        input  busy, term_ready, mac_a, mac_b, mac_c, mac_sub, mac_clken, res_valid, res_data
    );

    modport slave (
`ifdef CHOL_ACC_ADD_EN
        input  op_add,
`endif
        input  start, init_c, n_terms, term_valid, term_a, term_b, mac_out, res_ready,
        output busy, term_ready, mac_a, mac_b, mac_c, mac_sub, mac_clken, res_valid, res_data
    );

endinterface

// File: rtl/chol_lat_cnt.sv
// Loadable down-counter tracking cycles until the MAC result is valid.
// o_last is high while the count equals 1, i.e. on the final wait cycle.
module chol_lat_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/chol_acc_ctrl.sv
// Accumulation sequencer feeding the Cholesky MAC and closing its C feedback loop.
// Define CHOL_ACC_ADD_EN to add the op_add input (accumulate instead of subtract).
module chol_acc_ctrl
    import chol_pkg::*;
#(
    parameter int MAC_LATENCY = CHOL_MAC_LATENCY,
    parameter int CNT_W       = 6
) (
    input  logic            clk,
    input  logic            rst,
    chol_acc_ctrl_if.slave  bus
);

    localparam int LAT_W = $clog2(MAC_LATENCY + 1);

    chol_state_e           r_state, w_state_next;
    logic [CHOL_ACC_W-1:0] r_acc, w_acc_next;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next, w_cnt_dec;
    logic                  w_fire, w_lat_load, w_lat_dec, w_lat_last;

    assign w_fire    = (r_state == ST_ISSUE) && bus.term_valid;
    assign w_cnt_dec = r_cnt - CNT_W'(1);

    chol_lat_cnt #(
        .W (LAT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_lat_load),
        .i_load_val (LAT_W'(MAC_LATENCY)),
        .i_dec      (w_lat_dec),
        .o_last     (w_lat_last)
    );

`ifdef CHOL_ACC_ADD_EN
    // Holds the inverted op_add so that the reset value drives mac_sub low.
    logic r_sub, w_sub_next;

    always_ff @(posedge clk) begin
        if (rst) r_sub <= 1'b0;
        else     r_sub <= w_sub_next;
    end

    assign bus.mac_sub = r_sub;
`else
    assign bus.mac_sub = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_lat_load   = 1'b0;
        w_lat_dec    = 1'b0;
`ifdef CHOL_ACC_ADD_EN
        w_sub_next   = r_sub;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_acc_next = bus.init_c;
                    w_cnt_next = bus.n_terms;
`ifdef CHOL_ACC_ADD_EN
                    w_sub_next = ~bus.op_add;
`endif
                    w_state_next = (bus.n_terms == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.term_valid) begin
                    w_lat_load   = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_lat_dec = 1'b1;
                // The MAC result for the issued pair is valid on the last wait cycle.
                if (w_lat_last) begin
                    w_acc_next   = bus.mac_out;
                    w_cnt_next   = w_cnt_dec;
                    w_state_next = (w_cnt_dec == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.term_ready = (r_state == ST_ISSUE);
    assign bus.mac_a      = w_fire ? bus.term_a : '0;
    assign bus.mac_b      = w_fire ? bus.term_b : '0;
    assign bus.mac_c      = r_acc;
    assign bus.mac_clken  = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.res_valid  = (r_state == ST_DONE);
    assign bus.res_data   = r_acc;

endmodule

// File: tb/tb_chol_acc_ctrl.sv
// Randomised self-checking bench for chol_acc_ctrl with a behavioural 4-stage MAC.
// Expected results come from plain c -/+ sum(a*b) arithmetic and cycle formulas.
module tb_chol_acc_ctrl;

    localparam int LAT   = 4;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    chol_acc_ctrl_if #(.CNT_W(CNT_W)) bif ();

    chol_acc_ctrl #(
        .MAC_LATENCY (LAT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // Behavioural MAC: P = C -/+ A*B after LAT enabled clocks, cleared by rst.
    logic [63:0] mac_pipe [LAT];
    logic [63:0] mac_res;
    always_comb begin
        longint pa, pb, pc;
        pa = longint'($signed(bif.mac_a));
        pb = longint'($signed(bif.mac_b));
        pc = longint'(bif.mac_c);
        mac_res = bif.mac_sub ? 64'(pc - pa * pb) : 64'(pc + pa * pb);
    end
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mac_pipe[i] <= '0;
        end else if (bif.mac_clken) begin
            mac_pipe[0] <= mac_res;
            for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
        end
    end
    assign bif.mac_out = mac_pipe[LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] op_a [64];
    logic [31:0] op_b [64];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".busy"},       64'(bif.busy), 64'd0);
        check_eq({tag, ".term_ready"}, 64'(bif.term_ready), 64'd0);
        check_eq({tag, ".mac_a"},      64'(bif.mac_a), 64'd0);
        check_eq({tag, ".mac_b"},      64'(bif.mac_b), 64'd0);
        check_eq({tag, ".mac_c"},      bif.mac_c, 64'd0);
        check_eq({tag, ".mac_clken"},  64'(bif.mac_clken), 64'd0);
        check_eq({tag, ".res_valid"},  64'(bif.res_valid), 64'd0);
        check_eq({tag, ".res_data"},   bif.res_data, 64'd0);
`ifdef CHOL_ACC_ADD_EN
        check_eq({tag, ".mac_sub"},    64'(bif.mac_sub), 64'd0);
`else
        check_eq({tag, ".mac_sub"},    64'(bif.mac_sub), 64'd1);
`endif
    endtask

    // Runs one transaction from IDLE; called at #1 after a rising edge.
    task automatic run_txn(input logic [63:0] init, input int n, input int stall,
                           input int rr_low, input bit add, input int abort_cyc,
                           input string tag);
        longint exp_res, part, p;
        int cyc, k, sc, exp_lat;
        bit ready_seen, clken_seen, done;
        exp_res = longint'(init);
        for (int i = 0; i < n; i++) begin
            p = longint'($signed(op_a[i])) * longint'($signed(op_b[i]));
            exp_res = add ? exp_res + p : exp_res - p;
        end
        exp_lat = 1 + n * (LAT + 1 + stall);
        part = longint'(init);

        check_eq({tag, ".idle_busy"}, 64'(bif.busy), 64'd0);
        bif.init_c  = init;
        bif.n_terms = CNT_W'(n);
        bif.start   = 1'b1;
`ifdef CHOL_ACC_ADD_EN
        bif.op_add  = add;
`endif
        cyc = 0; k = 0; sc = 0; done = 0; ready_seen = 0; clken_seen = 0;
        while (!done) begin
            @(posedge clk); #1;
            cyc++;
            bif.start = 1'b0;
            if (bif.term_valid) begin
                p = longint'($signed(op_a[k])) * longint'($signed(op_b[k]));
                part = add ? part + p : part - p;
                bif.term_valid = 1'b0;
                k++;
                sc = 0;
            end
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_reset_outputs({tag, ".after_rst"});
                $display("txn %s: aborted by reset at cycle %0d", tag, cyc);
                return;
            end
            ready_seen |= bif.term_ready;
            clken_seen |= bif.mac_clken;
            if (bif.res_valid) begin
                done = 1;
            end else if (cyc > 1000) begin
                check_eq({tag, ".timeout"}, 64'(cyc), 64'(exp_lat));
                return;
            end else begin
                check_eq({tag, ".mac_a_quiet"}, 64'(bif.mac_a), 64'd0);
                if (bif.term_ready) begin
                    if (sc < stall) begin
                        sc++;
                    end else begin
                        bif.term_valid = 1'b1;
                        bif.term_a = op_a[k];
                        bif.term_b = op_b[k];
                        #1;
                        check_eq({tag, ".mac_a"}, 64'(bif.mac_a), 64'(op_a[k]));
                        check_eq({tag, ".mac_b"}, 64'(bif.mac_b), 64'(op_b[k]));
                        check_eq({tag, ".mac_c"}, bif.mac_c, 64'(part));
                    end
                end
            end
        end
        check_eq({tag, ".latency"},  64'(cyc), 64'(exp_lat));
        check_eq({tag, ".res_data"}, bif.res_data, 64'(exp_res));
        check_eq({tag, ".terms"},    64'(k), 64'(n));
        check_eq({tag, ".clken_done"}, 64'(bif.mac_clken), 64'd0);
        if (n == 0) begin
            check_eq({tag, ".no_ready"}, 64'(ready_seen), 64'd0);
            check_eq({tag, ".no_clken"}, 64'(clken_seen), 64'd0);
        end
        for (int j = 0; j < rr_low; j++) begin
            bif.start  = 1'b1;
            bif.init_c = ~init;
            @(posedge clk); #1;
            check_eq({tag, ".hold_valid"}, 64'(bif.res_valid), 64'd1);
            check_eq({tag, ".hold_data"},  bif.res_data, 64'(exp_res));
            check_eq({tag, ".hold_busy"},  64'(bif.busy), 64'd1);
        end
        // start coincident with the completing handshake must not begin a new job.
        bif.start     = 1'b1;
        bif.res_ready = 1'b1;
        @(posedge clk); #1;
        bif.start     = 1'b0;
        bif.res_ready = 1'b0;
        check_eq({tag, ".post_valid"}, 64'(bif.res_valid), 64'd0);
        check_eq({tag, ".post_busy"},  64'(bif.busy), 64'd0);
        $display("txn %s: n=%0d stall=%0d rr_low=%0d cycles=%0d res=%h", tag, n, stall, rr_low,
                 cyc, bif.res_data);
    endtask

    initial begin
        bif.start = 1'b0; bif.init_c = '0; bif.n_terms = '0;
        bif.term_valid = 1'b0; bif.term_a = '0; bif.term_b = '0;
        bif.res_ready = 1'b0;
`ifdef CHOL_ACC_ADD_EN
        bif.op_add = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        op_a[0] = 32'd2; op_b[0] = 32'd3;
        op_a[1] = 32'd4; op_b[1] = 32'd5;
        op_a[2] = 32'd1; op_b[2] = 32'd1;
        run_txn(64'd100, 3, 0, 0, 1'b0, 0, "t1_basic");
        run_txn(64'h1234, 0, 0, 0, 1'b0, 0, "t2_zero");
        run_txn(64'd100, 3, 3, 0, 1'b0, 0, "t3_stall");
        run_txn(64'd100, 3, 0, 5, 1'b0, 0, "t4_backpr");
        run_txn(64'd100, 3, 0, 0, 1'b0, 8, "t5_abort");
        op_a[0] = 32'd1; op_b[0] = 32'd2;
        run_txn(64'd10, 1, 0, 0, 1'b0, 0, "t5_after");
        op_a[0] = 32'hFFFF_FFFD; op_b[0] = 32'd7;
        run_txn(64'd0, 1, 0, 0, 1'b0, 0, "t6_sub");
`ifdef CHOL_ACC_ADD_EN
        run_txn(64'd0, 1, 0, 0, 1'b1, 0, "t6_add");
`endif
        for (int t = 0; t < 20; t++) begin
            int n;
            bit add;
            n = int'($urandom_range(0, 5));
            for (int i = 0; i < n; i++) begin
                op_a[i] = $urandom;
                op_b[i] = $urandom;
            end
`ifdef CHOL_ACC_ADD_EN
            add = bit'($urandom_range(0, 1));
`else
            add = 1'b0;
`endif
            run_txn({$urandom, $urandom}, n, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), add, 0, $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
